// File: rtl/pixel_row_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_row_streamer
//  Brief    : Streams a band of image rows from a synchronous pixel RAM in
//             raster order, tagging each pixel with its row and column.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_row_streamer #(
    parameter int PIXEL_W = 12,
    parameter int COL_LEN = 640,
    parameter int ROW_LEN = 480,
    parameter int ROW_W   = 10,
    parameter int COL_W   = 10,
    parameter int ADDR_W  = 19
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [ROW_W-1:0]   row_select_i,
    input  logic [ROW_W-1:0]   range_size_i,
    output logic               mem_rd_en_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [PIXEL_W-1:0] mem_rd_data_i,
    output logic [PIXEL_W-1:0] pixel_o,
    output logic [ROW_W-1:0]   row_index_o,
    output logic [COL_W-1:0]   column_index_o,
    output logic               strobe_o,
    input  logic               ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int E_W = PIXEL_W + ROW_W + COL_W;

    localparam logic [ROW_W:0]    c_ROW_LEN  = (ROW_W+1)'(ROW_LEN);
    localparam logic [ROW_W:0]    c_ONE_R    = (ROW_W+1)'(1);
    localparam logic [COL_W-1:0]  c_COL_LAST = COL_W'(COL_LEN - 1);
    localparam logic [ADDR_W-1:0] c_COL_LEN  = ADDR_W'(COL_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ROW_W-1:0]   rd_row_q;
    logic [COL_W-1:0]   rd_col_q;
    logic [ROW_W:0]     end_row_q;
    logic               remain_q;
    logic               infl_q;
    logic [ROW_W-1:0]   infl_row_q;
    logic [COL_W-1:0]   infl_col_q;
    logic [E_W-1:0]     b0_q, b1_q, b0_d, b1_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               busy_q;
    logic               done_q;

    logic               w_pop;
    logic               w_push;
    logic [2:0]         w_occ;
    logic               w_rd_en;
    logic               w_last_rd;
    logic               w_drain;
    logic               w_clip;
    logic [ROW_W:0]     w_sum;
    logic [ROW_W:0]     w_end;
    logic [E_W-1:0]     w_new;

    assign w_pop   = (cnt_q != 2'd0) && ready_i;
    assign w_push  = infl_q;
    assign w_occ   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, w_pop};
    assign w_rd_en = (state_q == S_RUN) && remain_q && (w_occ < 3'd2);

    assign w_last_rd = (rd_col_q == c_COL_LAST) && (({1'b0, rd_row_q} + c_ONE_R) == end_row_q);
    // Band is finished once nothing is left to read and the buffer empties this cycle
    assign w_drain   = !remain_q && !infl_q && (cnt_q == (w_pop ? 2'd1 : 2'd0));

    assign w_sum  = {1'b0, row_select_i} + {1'b0, range_size_i};
    assign w_end  = (w_sum > c_ROW_LEN) ? c_ROW_LEN : w_sum;
    assign w_clip = (range_size_i == '0) || ({1'b0, row_select_i} >= c_ROW_LEN);
    assign w_new  = {mem_rd_data_i, infl_row_q, infl_col_q};

    always_comb begin
        b0_d  = b0_q;
        b1_d  = b1_q;
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b01: begin
                b0_d  = b1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) b0_d = w_new;
                else               b1_d = w_new;
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    b0_d = w_new;
                end else begin
                    b0_d = b1_q;
                    b1_d = w_new;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            end_row_q  <= '0;
            remain_q   <= 1'b0;
            infl_q     <= 1'b0;
            infl_row_q <= '0;
            infl_col_q <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            cnt_q      <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            b0_q   <= b0_d;
            b1_q   <= b1_d;
            cnt_q  <= cnt_d;
            infl_q <= w_rd_en;
            if (w_rd_en) begin
                infl_row_q <= rd_row_q;
                infl_col_q <= rd_col_q;
                // Address and tags stay on the final pixel rather than run past the band
                if (w_last_rd) begin
                    remain_q <= 1'b0;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (rd_col_q == c_COL_LAST) begin
                        rd_col_q <= '0;
                        rd_row_q <= rd_row_q + ROW_W'(1);
                    end else begin
                        rd_col_q <= rd_col_q + COL_W'(1);
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (w_clip) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RUN;
                            addr_q    <= ADDR_W'(row_select_i) * c_COL_LEN;
                            rd_row_q  <= row_select_i;
                            rd_col_q  <= '0;
                            end_row_q <= w_end;
                            remain_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_drain) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {pixel_o, row_index_o, column_index_o} = b0_q;
    assign strobe_o    = (cnt_q != 2'd0);
    assign mem_rd_en_o = w_rd_en;
    assign mem_addr_o  = addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_row_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_row_streamer
//  Brief    : Self-checking bench for pixel_row_streamer (COL_LEN=4, ROW_LEN=3,
//             RAM[a]=a) against a queue-based band model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_row_streamer;

    localparam int PW = 8;
    localparam int CL = 4;
    localparam int RL = 3;
    localparam int RW = 3;
    localparam int CW = 2;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] rsel = '0;
    logic [RW-1:0] rsz = '0;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [PW-1:0] rdata = '0;
    logic [PW-1:0] pixel;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          strobe;
    logic          ready = 1'b0;
    logic          busy;
    logic          done;

    pixel_row_streamer #(
        .PIXEL_W(PW), .COL_LEN(CL), .ROW_LEN(RL),
        .ROW_W(RW), .COL_W(CW), .ADDR_W(AW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .row_select_i(rsel), .range_size_i(rsz),
        .mem_rd_en_o(rd_en), .mem_addr_o(addr), .mem_rd_data_i(rdata),
        .pixel_o(pixel), .row_index_o(row), .column_index_o(col),
        .strobe_o(strobe), .ready_i(ready), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with RAM[a]=a; junk on cycles without a read
    always @(posedge clk) rdata <= rd_en ? PW'(addr) : PW'($urandom);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int pix;
        int row;
        int col;
    } ent_t;

    ent_t   expq[$];
    int     rdq[$];
    int     log_q[$];
    ent_t   e;
    bit     m_busy = 0;
    int     exp_done_at = -1;
    int     start_cyc = 0;
    bit     first_pend = 0;
    bit     prev_stall = 0;
    bit     rst_prev = 0;
    int     pv_pix, pv_row, pv_col;
    int     ready_mode = 0;

    // Reference model and per-cycle compare
    always @(negedge clk) begin
        if (rst_prev) begin
            chk("rst_pixel", pixel, 0);
            chk("rst_row", row, 0);
            chk("rst_col", col, 0);
            chk("rst_strobe", strobe, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_addr", addr, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end
        if (rst) begin
            expq.delete();
            rdq.delete();
            m_busy      = 0;
            exp_done_at = -1;
            first_pend  = 0;
            prev_stall  = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_strobe", strobe, 1);
                chk("stall_pixel", pixel, pv_pix);
                chk("stall_row", row, pv_row);
                chk("stall_col", col, pv_col);
            end
            chk("busy", busy, m_busy);
            if (done || cyc == exp_done_at)
                chk("done", done, cyc == exp_done_at);
            if (rd_en) begin
                if (rdq.size() == 0) begin
                    chk("rd_en_unexpected", 1, 0);
                end else begin
                    int a;
                    a = rdq.pop_front();
                    chk("rd_addr", addr, a);
                end
            end
            if (strobe) begin
                if (first_pend) begin
                    chk("latency", cyc - start_cyc, 3);
                    first_pend = 0;
                end
                if (expq.size() == 0) begin
                    chk("strobe_unexpected", 1, 0);
                end else begin
                    e = expq[0];
                    chk("pixel", pixel, e.pix);
                    chk("row_index", row, e.row);
                    chk("column_index", col, e.col);
                    if (ready) begin
                        void'(expq.pop_front());
                        log_q.push_back(int'(pixel));
                        if (expq.size() == 0) exp_done_at = cyc + 1;
                    end
                end
            end
            prev_stall = strobe && !ready;
            pv_pix = pixel;
            pv_row = row;
            pv_col = col;
            if (start && !m_busy) begin
                int rs, sz, er;
                rs = int'(rsel);
                sz = int'(rsz);
                m_busy = 1;
                if (sz == 0 || rs >= RL) begin
                    exp_done_at = cyc + 1;
                end else begin
                    er = (rs + sz > RL) ? RL : rs + sz;
                    for (int r = rs; r < er; r++)
                        for (int c = 0; c < CL; c++) begin
                            expq.push_back('{r * CL + c, r, c});
                            rdq.push_back(r * CL + c);
                        end
                    start_cyc  = cyc;
                    first_pend = 1;
                end
            end else if (cyc == exp_done_at) begin
                m_busy = 0;
            end
            if (cyc == exp_done_at && m_busy && !(start && cyc == start_cyc)) m_busy = 0;
        end
        rst_prev = rst;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic do_start(input int rs, input int sz);
        @(posedge clk);
        #1;
        start = 1'b1;
        rsel  = RW'(rs);
        rsz   = RW'(sz);
        @(posedge clk);
        #1;
        start = 1'b0;
        rsel  = RW'($urandom);
        rsz   = RW'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_busy) chk("band_timeout", 0, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single row, continuous ready
        ready_mode = 0;
        log_q.delete();
        do_start(1, 1);
        wait_idle(60);
        chk("t1_count", log_q.size(), 4);
        for (int i = 0; i < log_q.size() && i < 4; i++) chk("t1_pixel", log_q[i], 4 + i);

        // Band clipped at the bottom of the frame
        log_q.delete();
        do_start(1, 5);
        wait_idle(80);
        chk("t2_count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            chk("t2_first", log_q[0], 4);
            chk("t2_last", log_q[7], 11);
        end

        // Empty bands
        log_q.delete();
        do_start(1, 0);
        wait_idle(20);
        do_start(3, 2);
        wait_idle(20);
        chk("t3_count", log_q.size(), 0);

        // Whole frame with ready toggling
        ready_mode = 1;
        log_q.delete();
        do_start(0, 3);
        wait_idle(120);
        chk("t4_count", log_q.size(), 12);
        for (int i = 0; i < log_q.size() && i < 12; i++) chk("t4_pixel", log_q[i], i);

        // Reset mid-band, then restart
        ready_mode = 0;
        log_q.delete();
        do_start(0, 3);
        begin
            int n;
            n = 0;
            while (log_q.size() < 5 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (log_q.size() < 5) chk("t5_timeout", 0, 1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        log_q.delete();
        do_start(0, 1);
        wait_idle(60);
        chk("t5_count", log_q.size(), 4);
        if (log_q.size() > 0) chk("t5_first", log_q[0], 0);

        // Start pulsed while busy is ignored
        log_q.delete();
        do_start(0, 2);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        rsel  = RW'(2);
        rsz   = RW'(1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(80);
        chk("t6_count", log_q.size(), 8);
        if (log_q.size() == 8) chk("t6_last", log_q[7], 7);

        // Randomized bands, back-pressure and stray starts
        ready_mode = 2;
        for (int k = 0; k < 30; k++) begin
            do_start($urandom_range(0, 5), $urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 12)) @(posedge clk);
                #1;
                start = 1'b1;
                rsel  = RW'($urandom_range(0, 4));
                rsz   = RW'($urandom_range(0, 4));
                @(posedge clk);
                #1 start = 1'b0;
            end
            wait_idle(300);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
